// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter: FSM state encoding and the no-grant id.
// The optional lock feature is enabled by defining ARB_RR_LOCK_EN.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // gnt_id carries the value NUM_REQ whenever no grant is presented.
    function automatic int unsigned no_grant_id(input int unsigned num_req);
        return num_req;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0, find the first
// set bit with fixed priority, then rotate the index back into requester space.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot;
    logic [PTR_W-1:0]   first;
    int                 src;
    int                 sum;

    always_comb begin
        rot   = '0;
        src   = 0;
        first = '0;
        sum   = 0;

        for (int i = 0; i < NUM_REQ; i++) begin
            src = i + int'(ptr);
            if (src >= NUM_REQ) begin
                src = src - NUM_REQ;
            end
            rot[i] = req[src];
        end

        found = |rot;

        // Scan downward so the lowest set bit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first = PTR_W'(i);
            end
        end

        sum = int'(first) + int'(ptr);
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        idx = PTR_W'(sum);
    end

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin arbiter with a registered grant held until accepted via valid/ready.
// Defining ARB_RR_LOCK_EN adds a lock input that lets the current winner burst.
module arbiter_rr
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ + 1),
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
`ifdef ARB_RR_LOCK_EN
    input  logic               lock,
`endif
    output logic               gnt_valid,
    input  logic               gnt_ready,
    output logic [ID_W-1:0]    gnt_id,
    output logic [NUM_REQ-1:0] gnt_onehot
);

    localparam logic [ID_W-1:0] NO_GRANT = ID_W'(no_grant_id(NUM_REQ));

    // Handshake: a grant transfers on any rising edge where gnt_valid && gnt_ready;
    // until then gnt_id/gnt_onehot/gnt_valid are frozen regardless of req.
    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [NUM_REQ-1:0] gnt_onehot_q, gnt_onehot_d;

    logic               transfer;
    logic               regrant;
    logic [PTR_W-1:0]   cur_idx;
    logic [PTR_W-1:0]   inc_ptr;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr_d),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_id_d     = gnt_id_q;
        gnt_onehot_d = gnt_onehot_q;
        regrant      = 1'b0;

        transfer = (state_q == ARB_GRANT) && gnt_ready;
        cur_idx  = PTR_W'(gnt_id_q);
        inc_ptr  = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : PTR_W'(gnt_id_q + 1'b1);

        if (transfer) begin
            ptr_d = inc_ptr;
`ifdef ARB_RR_LOCK_EN
            // A locked transfer keeps the winner as long as it still requests.
            if (lock && req[cur_idx]) begin
                ptr_d   = ptr_q;
                regrant = 1'b1;
            end
`endif
        end

        if ((state_q == ARB_IDLE) || transfer) begin
            if (regrant) begin
                state_d = ARB_GRANT;
            end else if (pick_found) begin
                state_d      = ARB_GRANT;
                gnt_id_d     = ID_W'(pick_idx);
                gnt_onehot_d = NUM_REQ'(1) << pick_idx;
            end else begin
                state_d      = ARB_IDLE;
                gnt_id_d     = NO_GRANT;
                gnt_onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= '0;
            gnt_id_q     <= NO_GRANT;
            gnt_onehot_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_id_q     <= gnt_id_d;
            gnt_onehot_q <= gnt_onehot_d;
        end
    end

    assign gnt_valid  = (state_q == ARB_GRANT);
    assign gnt_id     = gnt_id_q;
    assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr (NUM_REQ=4): directed cases with literal expectations plus
// random traffic compared every cycle against a round-robin reference model.
module tb_arbiter_rr;

    localparam int N    = 4;
    localparam int ID_W = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic           gnt_ready = 1'b0;
    logic           lock = 1'b0;
    logic           gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic [N-1:0]   gnt_onehot;

    int tests = 0;
    int fails = 0;

    // Reference model state: what is granted and where priority starts.
    bit m_valid = 1'b0;
    int m_id    = N;
    int m_ptr   = 0;

    arbiter_rr #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
`ifdef ARB_RR_LOCK_EN
        .lock       (lock),
`endif
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_id     (gnt_id),
        .gnt_onehot (gnt_onehot)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First requester found scanning p, p+1, ... with wrap; -1 when nobody requests.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_id    <= N;
            m_ptr   <= 0;
        end else if (m_valid && gnt_ready && lock && req[m_id]) begin
            m_valid <= 1'b1;
        end else if (m_valid && gnt_ready) begin
            m_ptr   <= (m_id + 1) % N;
            m_valid <= pick(req, (m_id + 1) % N) >= 0;
            m_id    <= (pick(req, (m_id + 1) % N) >= 0) ? pick(req, (m_id + 1) % N) : N;
        end else if (!m_valid) begin
            m_valid <= pick(req, m_ptr) >= 0;
            m_id    <= (pick(req, m_ptr) >= 0) ? pick(req, m_ptr) : N;
        end
    end

    always @(negedge clk) begin
        check("cyc_valid", 32'(gnt_valid), 32'(m_valid));
        check("cyc_id", 32'(gnt_id), 32'(m_id));
        check("cyc_onehot", 32'(gnt_onehot), m_valid ? (32'd1 << m_id) : 32'd0);
    end

    task automatic expect_grant(input string name, input bit v, input int id);
        check({name, "_valid"}, 32'(gnt_valid), 32'(v));
        check({name, "_id"}, 32'(gnt_id), 32'(id));
        check({name, "_onehot"}, 32'(gnt_onehot), v ? (32'd1 << id) : 32'd0);
        check({name, "_model_id"}, 32'(m_id), 32'(id));
    endtask

    task automatic do_reset(input logic [N-1:0] r, input logic rdy);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req = r;
        gnt_ready = rdy;
        #1;
        expect_grant("reset", 1'b0, N);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int seq2 [4] = '{0, 2, 0, 2};

        // Rotation over all four requesters with the consumer always ready.
        do_reset(4'b1111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            expect_grant("rotate", 1'b1, k % N);
        end

        // Sparse requests, then drain to idle one cycle after the last transfer.
        do_reset(4'b0101, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            expect_grant("sparse", 1'b1, seq2[k]);
        end
        #1 req = 4'b0000;
        @(negedge clk); #1;
        expect_grant("drain", 1'b0, N);

        // Grant held while not ready even when req changes underneath it.
        do_reset(4'b1000, 1'b0);
        @(negedge clk); #1;
        expect_grant("hold_first", 1'b1, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            expect_grant("hold", 1'b1, 3);
            #1;
            req = 4'b0001;
            if (c == 2) gnt_ready = 1'b1;
        end
        @(negedge clk); #1;
        expect_grant("after_hold", 1'b1, 0);

        // Asynchronous reset in the middle of a pending grant.
        do_reset(4'b0100, 1'b0);
        @(negedge clk); #1;
        expect_grant("pending", 1'b1, 2);
        #1 rst_n = 1'b0;
        #1;
        expect_grant("async_clear", 1'b0, N);
        req = 4'b1111;
        gnt_ready = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
        expect_grant("restart", 1'b1, 0);

`ifdef ARB_RR_LOCK_EN
        // Locked transfers re-grant the same winner; unlocking lets the next one in.
        do_reset(4'b0011, 1'b1);
        lock = 1'b1;
        @(negedge clk); #1;
        expect_grant("lock0", 1'b1, 0);
        @(negedge clk); #1;
        expect_grant("lock1", 1'b1, 0);
        @(negedge clk); #1;
        expect_grant("lock2", 1'b1, 0);
        #1 lock = 1'b0;
        @(negedge clk); #1;
        expect_grant("unlock", 1'b1, 1);
`endif

        // Random traffic with occasional asynchronous resets, checked every cycle.
        do_reset(4'b0000, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #2;
            if ($urandom_range(0, 3) != 0) req = N'($urandom_range(0, (1 << N) - 1));
            gnt_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_RR_LOCK_EN
            lock = ($urandom_range(0, 2) == 0);
`endif
            rst_n = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Parametrised round-robin arbiter; successor to the fixed-priority 4-input arbiter.
- Arbitrates NUM_REQ request lines and issues one registered grant (index plus one-hot) through a valid/ready handshake.
- Rotating priority guarantees fairness; the grant is held stable until the downstream consumer accepts it.
- Sits between requesting agents and a shared resource (bus, memory port, output queue).

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..64.
- ID_W, $clog2(NUM_REQ+1), width of gnt_id; sized to encode the no-grant value NUM_REQ. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  NUM_REQ  request vector; bit i is requester i.
- gnt_valid  output  1  grant presented this cycle.
- gnt_ready  input  1  consumer accepts grant; transfer = gnt_valid && gnt_ready.
- gnt_id  output  ID_W  granted index; NUM_REQ when no grant.
- gnt_onehot  output  NUM_REQ  one-hot grant; all zero when no grant.

Behaviour:
- Reset (rst_n low, asynchronous): state ARB_IDLE, gnt_valid=0, gnt_id=NUM_REQ, gnt_onehot=0, priority pointer ptr=0 (req[0] highest).
- Pick function: first set bit of req scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
- ARB_IDLE:
  - If any req bit is set at an edge: register the pick into gnt_id/gnt_onehot, set gnt_valid=1, go to ARB_GRANT.
  - Latency: one cycle from req sampled to gnt_valid high.
  - Otherwise remain in ARB_IDLE with outputs at their reset values.
- ARB_GRANT:
  - gnt_id, gnt_onehot and gnt_valid are held stable while gnt_ready=0, even if req changes or the granted req drops. A grant is never revoked.
  - On transfer: ptr_next = (gnt_id+1) mod NUM_REQ, wrapping at NUM_REQ-1.
  - Also on transfer, the pick is computed with ptr_next over the current req in the same cycle.
  - If that pick finds a request: load it, stay in ARB_GRANT, gnt_valid remains 1 (back-to-back grant, no bubble).
  - Otherwise: go to ARB_IDLE, gnt_valid=0, gnt_id=NUM_REQ, gnt_onehot=0.
- ptr changes only on transfer (or reset).
- The just-granted requester becomes lowest priority. Any continuously asserted request is granted within NUM_REQ transfers.
- gnt_onehot always equals decode(gnt_id) when gnt_valid=1.
- NUM_REQ=1: ptr stays 0; gnt_id is 0 or 1.
- Reset asserted mid-grant clears all outputs immediately with no completion of the handshake. After release, arbitration restarts from ptr=0.
- gnt_ready while gnt_valid=0 is ignored.

Optional Feature:
- Macro ARB_RR_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - A transfer with lock=1 leaves ptr unchanged and re-grants the same index back-to-back if its req bit is still set; this allows bursts.
  - If that req bit is clear, arbitration proceeds from gnt_id+1 as in the unlocked case.
  - lock is ignored without a transfer.
- Undefined: no lock port; every transfer advances ptr.

Decomposition:
- Package arb_pkg:
  - enum arb_state_e {ARB_IDLE, ARB_GRANT}.
  - Function/constant for the no-grant encoding.
- Sub-module rr_pick (purely combinational): inputs req, ptr; outputs found and idx.
  - Implemented as rotate, then fixed-priority find-first, then un-rotate.
  - Instantiated once, fed by ptr_next.

Test Plan (NUM_REQ=4):
- rst_n=0 with req=1111 -> gnt_valid=0, gnt_id=4, gnt_onehot=0000 immediately. First grant after release is id 0.
- req=1111, gnt_ready=1 constant -> gnt_id sequence 0,1,2,3,0,1 on consecutive cycles; gnt_valid never drops.
- req=0101, gnt_ready=1 -> gnt_id 0,2,0,2. Then req=0000 -> gnt_valid=0 and gnt_id=4 one cycle after the last transfer.
- Hold/stability case:
  - Stimulus: req=1000, gnt_ready=0 for 3 cycles; change req to 0001 while holding.
  - Response: gnt_id stays 3 and gnt_onehot stays 1000; on gnt_ready=1, next grant is 0.
- rst_n pulsed low while gnt_id=2 is pending -> outputs clear asynchronously. After release with req=1111, the grant is 0, not 3.
- ARB_RR_LOCK_EN defined:
  - Stimulus: req=0011, lock=1 for the first 3 transfers, then lock=0.
  - Response: gnt_id 0,0,0,then 1.
